// File: rtl/rst_seq.sv
// Board reset sequencer: key/PLL synchronization, key debounce, timed sys-then-cpu release.
// Optional watchdog reset enabled by defining RST_SEQ_WDT_EN.
module rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLDOFF_CYCLES  = 16,
  parameter int CPU_DELAY       = 8,
  parameter int WDT_CYCLES      = 1048576
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_ni,
  input  logic       pll_locked_i,
  input  logic       dbg_rst_req_i,
  input  logic       wdt_kick_i,
  output logic       sys_rst_no,
  output logic       cpu_rst_no,
  output logic [2:0] rst_cause_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_HOLD,
    ST_SYS_UP,
    ST_RUN,
    ST_DBG
  } state_t;

  localparam logic [2:0] CAUSE_POR   = 3'b000;
  localparam logic [2:0] CAUSE_KEY   = 3'b001;
  localparam logic [2:0] CAUSE_PLL   = 3'b010;
  localparam logic [2:0] CAUSE_DEBUG = 3'b011;
  localparam logic [2:0] CAUSE_WDT   = 3'b100;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // One timer serves both HOLD and SYS_UP, so size it for the longer of the two.
  localparam int TMAX = (HOLDOFF_CYCLES > CPU_DELAY) ? HOLDOFF_CYCLES : CPU_DELAY;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0] CPU_LAST  = TW'(CPU_DELAY - 1);

  logic [SYNC_STAGES-1:0] keySync_q;
  logic [SYNC_STAGES-1:0] pllSync_q;
  logic                   keySynced;
  logic                   pllSynced;

  logic [DW-1:0] dbCnt_q, dbCnt_d;
  logic          stableKey_q, stableKey_d;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sysRstN_q, sysRstN_d;
  logic          cpuRstN_q, cpuRstN_d;
  logic [2:0]    cause_q, cause_d;
  logic          busy_q, busy_d;

  logic keyPressed;
  logic pllLost;
  logic wdtExpire;

  // Key resets to released and PLL to unlocked so nothing is seen as an event out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      keySync_q <= '1;
      pllSync_q <= '0;
    end else begin
      keySync_q <= {keySync_q[SYNC_STAGES-2:0], key_ni};
      pllSync_q <= {pllSync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign keySynced = keySync_q[SYNC_STAGES-1];
  assign pllSynced = pllSync_q[SYNC_STAGES-1];

  always_comb begin
    dbCnt_d     = '0;
    stableKey_d = stableKey_q;
    if (keySynced != stableKey_q) begin
      if (dbCnt_q == DB_LAST) begin
        stableKey_d = keySynced;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbCnt_q     <= '0;
      stableKey_q <= 1'b1;
    end else begin
      dbCnt_q     <= dbCnt_d;
      stableKey_q <= stableKey_d;
    end
  end

  assign keyPressed = ~stableKey_q;
  assign pllLost    = ~pllSynced;

`ifdef RST_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdtCnt_q, wdtCnt_d;

  always_comb begin
    wdtCnt_d = wdtCnt_q;
    if ((state_q != ST_RUN) || wdt_kick_i) begin
      wdtCnt_d = '0;
    end else if (wdtCnt_q != WDT_LAST) begin
      wdtCnt_d = wdtCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdtCnt_q <= '0;
    end else begin
      wdtCnt_q <= wdtCnt_d;
    end
  end

  assign wdtExpire = (state_q == ST_RUN) && !wdt_kick_i && (wdtCnt_q == WDT_LAST);
`else
  localparam int unusedWdtCycles = WDT_CYCLES;
  logic unusedWdtKick;
  assign unusedWdtKick = wdt_kick_i;
  assign wdtExpire     = 1'b0;
`endif

  // Abort priority everywhere is PLL loss, then key, then watchdog, then debug.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sysRstN_d = sysRstN_q;
    cpuRstN_d = cpuRstN_q;
    cause_d   = cause_q;

    unique case (state_q)
      ST_RESET: begin
        state_d   = ST_WAIT_LOCK;
        timer_d   = '0;
        sysRstN_d = 1'b0;
        cpuRstN_d = 1'b0;
      end

      ST_WAIT_LOCK: begin
        sysRstN_d = 1'b0;
        cpuRstN_d = 1'b0;
        timer_d   = '0;
        if (pllSynced && !keyPressed) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (pllLost || keyPressed) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d   = ST_SYS_UP;
          timer_d   = '0;
          sysRstN_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_SYS_UP: begin
        if (pllLost || keyPressed) begin
          state_d   = ST_WAIT_LOCK;
          timer_d   = '0;
          sysRstN_d = 1'b0;
          cpuRstN_d = 1'b0;
          cause_d   = pllLost ? CAUSE_PLL : CAUSE_KEY;
        end else if (timer_q == CPU_LAST) begin
          state_d   = ST_RUN;
          timer_d   = '0;
          cpuRstN_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (pllLost || keyPressed || wdtExpire) begin
          state_d   = ST_WAIT_LOCK;
          timer_d   = '0;
          sysRstN_d = 1'b0;
          cpuRstN_d = 1'b0;
          if (pllLost) begin
            cause_d = CAUSE_PLL;
          end else if (keyPressed) begin
            cause_d = CAUSE_KEY;
          end else begin
            cause_d = CAUSE_WDT;
          end
        end else if (dbg_rst_req_i) begin
          state_d   = ST_DBG;
          cpuRstN_d = 1'b0;
          cause_d   = CAUSE_DEBUG;
        end
      end

      ST_DBG: begin
        cpuRstN_d = 1'b0;
        if (pllLost || keyPressed) begin
          state_d   = ST_WAIT_LOCK;
          timer_d   = '0;
          sysRstN_d = 1'b0;
          cause_d   = pllLost ? CAUSE_PLL : CAUSE_KEY;
        end else if (!dbg_rst_req_i) begin
          state_d = ST_SYS_UP;
          timer_d = '0;
        end
      end

      default: begin
        state_d   = ST_RESET;
        timer_d   = '0;
        sysRstN_d = 1'b0;
        cpuRstN_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RESET;
      timer_q   <= '0;
      sysRstN_q <= 1'b0;
      cpuRstN_q <= 1'b0;
      cause_q   <= CAUSE_POR;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sysRstN_q <= sysRstN_d;
      cpuRstN_q <= cpuRstN_d;
      cause_q   <= cause_d;
      busy_q    <= busy_d;
    end
  end

  assign sys_rst_no  = sysRstN_q;
  assign cpu_rst_no  = cpuRstN_q;
  assign rst_cause_o = cause_q;
  assign busy_o      = busy_q;

endmodule
